// File: rtl/dco_word_monitor_pkg.sv
// Shared constants, state encodings and decode helpers for the DCO word monitor.
package dco_word_monitor_pkg;

   localparam int N_L      = 5;
   localparam int N_MS     = 16;
   localparam int OFF_L    = 13;
   localparam int OFF_MS   = 128;
   localparam int WMAX_L   = 25;
   localparam int WMAX_MS  = 255;
   localparam int DEC_W    = 9;
   localparam int CNT_BITS = 8;

   typedef enum logic [1:0] {
      ST_UNSET   = 2'd0,
      ST_COUNT   = 2'd1,
      ST_SETTLED = 2'd2
   } settle_e;

   typedef enum logic [1:0] {
      SN_IDLE = 2'd0,
      SN_CAP  = 2'd1,
      SN_HOLD = 2'd2
   } snap_e;

   typedef struct packed {
      settle_e st_l;
      settle_e st_m;
      settle_e st_s;
      snap_e   snap;
   } mon_dbg_t;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
      return c;
   endfunction

   // A thermometer code has no zero below its highest one, so v & (v+1) is zero.
   function automatic logic is_thermo16(input logic [15:0] v);
      return (v & (v + 16'd1)) == 16'd0;
   endfunction

endpackage

// File: rtl/dco_word_monitor_if.sv
// Bank code bus and snapshot handshake between the monitor and its driver/reader.
interface dco_word_monitor_if;
   logic        [4:0]  l_rall, l_row, l_col;
   logic        [15:0] m_rall, m_row, m_col;
   logic        [15:0] s_rall, s_row, s_col;

   // snap_req is a level held by the reader; snap_ack high means snap_l/m/s are
   // captured and stable. Dropping snap_req releases them; snap_ack falls one cycle later.
   logic               snap_req;
   logic               snap_ack;
   logic signed [4:0]  snap_l;
   logic signed [7:0]  snap_m;
   logic signed [7:0]  snap_s;

   modport master (
      output l_rall, l_row, l_col, m_rall, m_row, m_col, s_rall, s_row, s_col, snap_req,
      input  snap_ack, snap_l, snap_m, snap_s
   );

   modport slave (
      input  l_rall, l_row, l_col, m_rall, m_row, m_col, s_rall, s_row, s_col, snap_req,
      output snap_ack, snap_l, snap_m, snap_s
   );
endinterface

// File: rtl/dco_word_monitor_row_col_dec.sv
// Combinational decode of one rall/row/col bank code into its unsigned index w and a legal flag.
module row_col_dec
   import dco_word_monitor_pkg::*;
#(
   parameter int N    = 16,
   parameter int WMAX = 255
) (
   input  logic [N-1:0]     rall_i,
   input  logic [N-1:0]     row_i,
   input  logic [N-1:0]     col_i,
   output logic [DEC_W-1:0] w_o,
   output logic             legal_o
);

   logic [15:0]  rall_x;
   logic [15:0]  col_x;
   logic [4:0]   q;
   logic [4:0]   r;
   logic [N-1:0] row_exp;

   always_comb begin
      rall_x          = '0;
      col_x           = '0;
      rall_x[N-1:0]   = rall_i;
      col_x[N-1:0]    = col_i;
      q               = popcount16(rall_x);
      r               = popcount16(col_x);
      // Row is one-hot at q, and empty once the coarse count has run off the end.
      row_exp = '0;
      for (int i = 0; i < N; i++) begin
         if (q == 5'(i)) row_exp[i] = 1'b1;
      end
      w_o     = DEC_W'(N) * DEC_W'(q) + DEC_W'(r);
      legal_o = is_thermo16(rall_x) && is_thermo16(col_x) && (row_i == row_exp) &&
                !((q == 5'(N)) && (r != '0)) && (w_o <= DEC_W'(WMAX));
   end

endmodule

// File: rtl/dco_word_monitor.sv
// DCO bank read-back monitor: decodes bank codes to signed words, flags illegal codes,
// tracks settling and serves snapshots. Optional min/max history: DCO_MON_HIST_EN.
module dco_word_monitor
   import dco_word_monitor_pkg::*;
#(
   parameter int SETTLE_CNT = 8,
   parameter int CNTW       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr,
   dco_word_monitor_if.slave      bus,
   output logic signed [4:0]      word_l,
   output logic signed [7:0]      word_m,
   output logic signed [7:0]      word_s,
   output logic                   settled_l,
   output logic                   settled_m,
   output logic                   settled_s,
   output logic                   err_l,
   output logic                   err_m,
   output logic                   err_s,
   output logic [CNTW-1:0]        chg_m,
   output logic [CNTW-1:0]        chg_s,
   output mon_dbg_t               dbg_o
`ifdef DCO_MON_HIST_EN
   ,
   output logic signed [7:0]      min_s,
   output logic signed [7:0]      max_s
`endif
);

   logic [4:0]          l_rall_q, l_row_q, l_col_q;
   logic [15:0]         m_rall_q, m_row_q, m_col_q;
   logic [15:0]         s_rall_q, s_row_q, s_col_q;
   logic [1:0]          mask_q;
   logic                mask_done;

   logic [DEC_W-1:0]    w_l, w_m, w_s;
   logic                leg_l, leg_m, leg_s;
   logic signed [4:0]   dec_l;
   logic signed [7:0]   dec_m, dec_s;

   logic signed [4:0]   word_l_q;
   logic signed [7:0]   word_m_q, word_s_q;
   logic                err_l_q, err_m_q, err_s_q;
   logic [CNTW-1:0]     chg_m_q, chg_s_q;

   logic [2:0]          legal, same;
   settle_e             st_q  [3];
   settle_e             st_d  [3];
   logic [CNT_BITS-1:0] cnt_q [3];
   logic [CNT_BITS-1:0] cnt_d [3];

   snap_e               snap_q, snap_d;
   logic signed [4:0]   snap_l_q;
   logic signed [7:0]   snap_m_q, snap_s_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_rall_q <= '0;  l_row_q <= '0;  l_col_q <= '0;
         m_rall_q <= '0;  m_row_q <= '0;  m_col_q <= '0;
         s_rall_q <= '0;  s_row_q <= '0;  s_col_q <= '0;
      end else if (en) begin
         l_rall_q <= bus.l_rall;  l_row_q <= bus.l_row;  l_col_q <= bus.l_col;
         m_rall_q <= bus.m_rall;  m_row_q <= bus.m_row;  m_col_q <= bus.m_col;
         s_rall_q <= bus.s_rall;  s_row_q <= bus.s_row;  s_col_q <= bus.s_col;
      end
   end

   row_col_dec #(.N(N_L), .WMAX(WMAX_L)) u_dec_l (
      .rall_i(l_rall_q), .row_i(l_row_q), .col_i(l_col_q), .w_o(w_l), .legal_o(leg_l)
   );
   row_col_dec #(.N(N_MS), .WMAX(WMAX_MS)) u_dec_m (
      .rall_i(m_rall_q), .row_i(m_row_q), .col_i(m_col_q), .w_o(w_m), .legal_o(leg_m)
   );
   row_col_dec #(.N(N_MS), .WMAX(WMAX_MS)) u_dec_s (
      .rall_i(s_rall_q), .row_i(s_row_q), .col_i(s_col_q), .w_o(w_s), .legal_o(leg_s)
   );

   assign dec_l     = 5'(w_l - DEC_W'(OFF_L));
   assign dec_m     = 8'(w_m - DEC_W'(OFF_MS));
   assign dec_s     = 8'(w_s - DEC_W'(OFF_MS));
   assign legal     = {leg_s, leg_m, leg_l};
   assign same      = {dec_s == word_s_q, dec_m == word_m_q, dec_l == word_l_q};
   // Stage-1 holds zeros for the first samples after reset; keep them out of the sticky errors.
   assign mask_done = (mask_q == 2'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q   <= '0;
         word_l_q <= '0;
         word_m_q <= '0;
         word_s_q <= '0;
         err_l_q  <= 1'b0;
         err_m_q  <= 1'b0;
         err_s_q  <= 1'b0;
         chg_m_q  <= '0;
         chg_s_q  <= '0;
      end else if (en) begin
         if (!mask_done) mask_q <= mask_q + 2'd1;
         if (leg_l) word_l_q <= dec_l;
         if (leg_m) word_m_q <= dec_m;
         if (leg_s) word_s_q <= dec_s;
         if (clr) begin
            err_l_q <= 1'b0;
            err_m_q <= 1'b0;
            err_s_q <= 1'b0;
            chg_m_q <= '0;
            chg_s_q <= '0;
         end else begin
            if (!leg_l && mask_done) err_l_q <= 1'b1;
            if (!leg_m && mask_done) err_m_q <= 1'b1;
            if (!leg_s && mask_done) err_s_q <= 1'b1;
            if (leg_m && !same[1] && (chg_m_q != '1)) chg_m_q <= chg_m_q + 1'b1;
            if (leg_s && !same[2] && (chg_s_q != '1)) chg_s_q <= chg_s_q + 1'b1;
         end
      end
   end

   always_comb begin
      for (int b = 0; b < 3; b++) begin
         st_d[b]  = st_q[b];
         cnt_d[b] = cnt_q[b];
         if (clr) begin
            st_d[b]  = ST_UNSET;
            cnt_d[b] = '0;
         end else begin
            case (st_q[b])
               ST_UNSET: begin
                  if (legal[b]) begin
                     st_d[b]  = (SETTLE_CNT == 1) ? ST_SETTLED : ST_COUNT;
                     cnt_d[b] = CNT_BITS'(1);
                  end
               end
               ST_COUNT: begin
                  if (!legal[b]) begin
                     st_d[b]  = ST_UNSET;
                     cnt_d[b] = '0;
                  end else if (!same[b]) begin
                     cnt_d[b] = CNT_BITS'(1);
                  end else if (({1'b0, cnt_q[b]} + 9'd1) >= 9'(SETTLE_CNT)) begin
                     st_d[b]  = ST_SETTLED;
                     cnt_d[b] = CNT_BITS'(SETTLE_CNT);
                  end else begin
                     cnt_d[b] = cnt_q[b] + 1'b1;
                  end
               end
               ST_SETTLED: begin
                  if (!legal[b]) begin
                     st_d[b]  = ST_UNSET;
                     cnt_d[b] = '0;
                  end else if (!same[b]) begin
                     st_d[b]  = ST_COUNT;
                     cnt_d[b] = CNT_BITS'(1);
                  end
               end
               default: begin
                  st_d[b]  = ST_UNSET;
                  cnt_d[b] = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 3; b++) begin
            st_q[b]  <= ST_UNSET;
            cnt_q[b] <= '0;
         end
      end else if (en) begin
         for (int b = 0; b < 3; b++) begin
            st_q[b]  <= st_d[b];
            cnt_q[b] <= cnt_d[b];
         end
      end
   end

   // Snapshot FSM: CAP always lasts exactly one cycle and HOLD at least one.
   always_comb begin
      snap_d = snap_q;
      case (snap_q)
         SN_IDLE: if (bus.snap_req) snap_d = SN_CAP;
         SN_CAP:  snap_d = SN_HOLD;
         SN_HOLD: if (!bus.snap_req) snap_d = SN_IDLE;
         default: snap_d = SN_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_q   <= SN_IDLE;
         snap_l_q <= '0;
         snap_m_q <= '0;
         snap_s_q <= '0;
      end else if (en) begin
         snap_q <= snap_d;
         if (snap_q == SN_CAP) begin
            snap_l_q <= word_l_q;
            snap_m_q <= word_m_q;
            snap_s_q <= word_s_q;
         end
      end
   end

`ifdef DCO_MON_HIST_EN
   logic signed [7:0] min_s_q, max_s_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_s_q <= 8'sh80;
         min_s_q <= 8'sh7F;
      end else if (en) begin
         if (clr) begin
            max_s_q <= 8'sh80;
            min_s_q <= 8'sh7F;
         end else if ((st_q[2] == ST_SETTLED) && leg_s) begin
            if (dec_s > max_s_q) max_s_q <= dec_s;
            if (dec_s < min_s_q) min_s_q <= dec_s;
         end
      end
   end

   assign min_s = min_s_q;
   assign max_s = max_s_q;
`endif

   assign word_l       = word_l_q;
   assign word_m       = word_m_q;
   assign word_s       = word_s_q;
   assign err_l        = err_l_q;
   assign err_m        = err_m_q;
   assign err_s        = err_s_q;
   assign chg_m        = chg_m_q;
   assign chg_s        = chg_s_q;
   assign settled_l    = (st_q[0] == ST_SETTLED);
   assign settled_m    = (st_q[1] == ST_SETTLED);
   assign settled_s    = (st_q[2] == ST_SETTLED);
   assign bus.snap_ack = (snap_q == SN_HOLD);
   assign bus.snap_l   = snap_l_q;
   assign bus.snap_m   = snap_m_q;
   assign bus.snap_s   = snap_s_q;
   assign dbg_o.st_l   = st_q[0];
   assign dbg_o.st_m   = st_q[1];
   assign dbg_o.st_s   = st_q[2];
   assign dbg_o.snap   = snap_q;

endmodule

// File: tb/tb_dco_word_monitor.sv
// Directed bench for dco_word_monitor: decode, legality, settling, change counts,
// snapshot handshake and asynchronous reset.
module tb_dco_word_monitor;
   import dco_word_monitor_pkg::*;

   logic              clk = 1'b0;
   logic              rst, en, clr;
   logic signed [4:0] word_l;
   logic signed [7:0] word_m, word_s;
   logic              settled_l, settled_m, settled_s;
   logic              err_l, err_m, err_s;
   logic [15:0]       chg_m, chg_s;
   mon_dbg_t          dbg;
`ifdef DCO_MON_HIST_EN
   logic signed [7:0] min_s, max_s;
`endif

   int n_pass  = 0;
   int n_total = 0;

   dco_word_monitor_if bus();

   dco_word_monitor #(.SETTLE_CNT(8), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .bus(bus),
      .word_l(word_l), .word_m(word_m), .word_s(word_s),
      .settled_l(settled_l), .settled_m(settled_m), .settled_s(settled_s),
      .err_l(err_l), .err_m(err_m), .err_s(err_s),
      .chg_m(chg_m), .chg_s(chg_s), .dbg_o(dbg)
`ifdef DCO_MON_HIST_EN
      , .min_s(min_s), .max_s(max_s)
`endif
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic set_l(input logic [4:0] ra, input logic [4:0] ro, input logic [4:0] co);
      bus.l_rall = ra;  bus.l_row = ro;  bus.l_col = co;
   endtask

   task automatic set_m(input logic [15:0] ra, input logic [15:0] ro, input logic [15:0] co);
      bus.m_rall = ra;  bus.m_row = ro;  bus.m_col = co;
   endtask

   task automatic set_s(input logic [15:0] ra, input logic [15:0] ro, input logic [15:0] co);
      bus.s_rall = ra;  bus.s_row = ro;  bus.s_col = co;
   endtask

   initial begin
      // clock/reset: legal codes already on the bus while rst is held
      rst = 1'b1;  en = 1'b1;  clr = 1'b0;  bus.snap_req = 1'b0;
      set_l(5'h00, 5'h01, 5'h00);               // w=0   -> -13
      set_m(16'h00FF, 16'h0100, 16'h0000);      // w=128 -> 0
      set_s(16'h00FF, 16'h0100, 16'h0000);      // w=128 -> 0
      step(1);
      chk("rst_word_l", word_l, 0);
      chk("rst_word_m", word_m, 0);
      chk("rst_err_m", err_m, 0);
      chk("rst_chg_m", chg_m, 0);
      chk("rst_settled_m", settled_m, 0);
      chk("rst_snap_ack", bus.snap_ack, 0);
      chk("rst_snap_m", bus.snap_m, 0);
      rst = 1'b0;
      step(2);
      chk("mask_err_l", err_l, 0);
      chk("mask_err_m", err_m, 0);
      chk("mask_err_s", err_s, 0);
      chk("first_word_l", word_l, -13);
      chk("first_chg_m", chg_m, 0);

      // medium bank: word 5 held, settles SETTLE_CNT+1 edges after it is presented
      set_m(16'h00FF, 16'h0100, 16'h001F);
      step(1);
      chk("m_latency", word_m, 0);
      step(1);
      chk("m_word5", word_m, 5);
      chk("m_chg1", chg_m, 1);
      chk("m_not_settled_b2", settled_m, 0);
      step(6);
      chk("m_not_settled_b8", settled_m, 0);
      step(1);
      chk("m_settled_b9", settled_m, 1);
      chk("m_dbg_settled", dbg.st_m, ST_SETTLED);
      step(1);
      chk("m_err", err_m, 0);
      chk("m_word_hold", word_m, 5);

      // large bank extremes
      set_l(5'h1F, 5'h00, 5'h00);
      step(2);
      chk("l_max", word_l, 12);
      chk("l_max_err", err_l, 0);
      chk("l_chg_m_unaff", chg_m, 1);
      set_l(5'h00, 5'h01, 5'h00);
      step(2);
      chk("l_min", word_l, -13);
      set_l(5'h03, 5'h01, 5'h00);               // row not at q=2
      step(1);
      chk("l_err_latency", err_l, 0);
      step(1);
      chk("l_err_set", err_l, 1);
      chk("l_word_held", word_l, -13);

      // small bank: illegal rall, then clr with the legal code back
      set_s(16'h00FF, 16'h0100, 16'h0001);      // word 1
      step(2);
      chk("s_word1", word_s, 1);
      chk("s_chg1", chg_s, 1);
      set_s(16'h0005, 16'h0100, 16'h0001);
      step(2);
      chk("s_err_set", err_s, 1);
      chk("s_word_held", word_s, 1);
      set_s(16'h00FF, 16'h0100, 16'h0000);      // word 0
      step(2);
      chk("s_word0", word_s, 0);
      chk("s_chg2", chg_s, 2);
      chk("s_err_sticky", err_s, 1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("clr_err_s", err_s, 0);
      chk("clr_wins_err_l", err_l, 0);
      chk("clr_chg_s", chg_s, 0);
      chk("clr_chg_m", chg_m, 0);
      step(1);
      chk("err_l_after_clr", err_l, 1);
      chk("err_s_after_clr", err_s, 0);

      // alternate word 0 / word 1 every cycle for 20 samples
      set_l(5'h00, 5'h01, 5'h00);
      for (int i = 0; i < 20; i++) begin
         set_s(16'h00FF, 16'h0100, (i % 2 == 1) ? 16'h0001 : 16'h0000);
         step(1);
      end
      step(1);
      chk("alt_chg_s", chg_s, 19);
      chk("alt_settled_s", settled_s, 0);
      chk("alt_word_s", word_s, 1);

      // en low freezes everything
      en = 1'b0;
      set_m(16'h00FF, 16'h0100, 16'h007F);      // word 7 if it were seen
      step(3);
      chk("en_hold_word_m", word_m, 5);
      set_m(16'h00FF, 16'h0100, 16'h001F);
      en = 1'b1;
      step(1);

      // snapshot: req high 5 cycles
      bus.snap_req = 1'b1;
      step(1);
      chk("snap_ack_c1", bus.snap_ack, 0);
      chk("snap_m_precap", bus.snap_m, 0);
      step(1);
      chk("snap_ack_c2", bus.snap_ack, 1);
      chk("snap_m_cap", bus.snap_m, 5);
      chk("snap_l_cap", bus.snap_l, -13);
      chk("snap_s_cap", bus.snap_s, 1);
      step(3);
      chk("snap_ack_c5", bus.snap_ack, 1);
      bus.snap_req = 1'b0;
      step(1);
      chk("snap_ack_fall", bus.snap_ack, 0);

      // req dropped during CAP still passes through HOLD once
      bus.snap_req = 1'b1;
      step(1);
      bus.snap_req = 1'b0;
      step(1);
      chk("cap_drop_hold", bus.snap_ack, 1);
      step(1);
      chk("cap_drop_idle", bus.snap_ack, 0);

      // asynchronous reset in HOLD
      bus.snap_req = 1'b1;
      step(2);
      chk("hold_before_rst", bus.snap_ack, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_ack", bus.snap_ack, 0);
      chk("rst_async_word_m", word_m, 0);
      chk("rst_async_word_s", word_s, 0);
      chk("rst_async_snap_m", bus.snap_m, 0);
      chk("rst_async_settled_m", settled_m, 0);
      chk("rst_async_err_l", err_l, 0);
      chk("rst_async_chg_s", chg_s, 0);
      bus.snap_req = 1'b0;
      step(1);
      rst = 1'b0;
      step(1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
